// File: rtl/arith_pkg.sv
// Shared arithmetic-unit types: Booth radix-4 opcodes, multiplier FSM states
// and the iteration-count helper.
package arith_pkg;

  typedef enum logic [2:0] {
    ZERO,
    PM,
    P2M,
    MM,
    M2M
  } booth_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Radix-4 steps needed to consume a (width+2)-bit extended multiplier.
  function automatic int unsigned n_iter(input int unsigned width);
    return (width + 2) / 2;
  endfunction

endpackage

// File: rtl/booth_radix4_mul_if.sv
// Request/result bundle of the radix-4 Booth multiplier.
interface booth_radix4_mul_if
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned CNT_W = $clog2(n_iter(WIDTH) + 1);

  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   is_signed;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;
  logic [CNT_W-1:0]       add_count;
  logic [CNT_W-1:0]       sub_count;

  modport master (
    output start, a, b, is_signed,
    input  busy, done, product, add_count, sub_count
  );

  modport slave (
    input  start, a, b, is_signed,
    output busy, done, product, add_count, sub_count
  );
endinterface

// File: rtl/booth_r4_recode.sv
// Combinational radix-4 Booth recoder: triplet (q[1], q[0], q[-1]) -> opcode.
module booth_r4_recode
  import arith_pkg::*;
(
  input  logic [2:0] trip,
  output booth_op_e  op_c
);

  always_comb begin
    op_c = ZERO;
    unique case (trip)
      3'b001, 3'b010: op_c = PM;
      3'b011:         op_c = P2M;
      3'b100:         op_c = M2M;
      3'b101, 3'b110: op_c = MM;
      default:        op_c = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_radix4_mul.sv
// Sequential signed/unsigned radix-4 Booth multiplier with busy/done handshake
// and per-operation add/sub step counts.
module booth_radix4_mul
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 32
)(
  input  logic              clk,
  input  logic              rst,
  booth_radix4_mul_if.slave bus
);

  localparam int unsigned N_ITER = n_iter(WIDTH);
  localparam int unsigned CNT_W  = $clog2(N_ITER + 1);
  localparam int unsigned XW     = WIDTH + 2;
  localparam int unsigned AW     = WIDTH + 4;

  state_e             state;
  logic [AW-1:0]      acc;
  logic [XW-1:0]      q;
  logic               q_m1;
  logic [XW-1:0]      m;
  logic [CNT_W-1:0]   iter;
  logic [CNT_W-1:0]   add_cnt;
  logic [CNT_W-1:0]   sub_cnt;

  booth_op_e          op_c;
  logic [AW-1:0]      m_ext_c;
  logic [AW-1:0]      addend_c;
  logic [AW-1:0]      sum_c;
  logic [AW-1:0]      acc_nx_c;
  logic [XW-1:0]      q_nx_c;
  logic               add_inc_c;
  logic               sub_inc_c;
  logic [XW-1:0]      a_ext_c;
  logic [XW-1:0]      b_ext_c;

  booth_r4_recode u_recode (
    .trip ({q[1:0], q_m1}),
    .op_c (op_c)
  );

  // Operand extension for the current request; the mode is captured in the
  // extended bits so no separate sign flag needs to be kept.
  always_comb begin
    a_ext_c = {2'b00, bus.a};
    b_ext_c = {2'b00, bus.b};
    if (bus.is_signed) begin
      a_ext_c = {{2{bus.a[WIDTH-1]}}, bus.a};
      b_ext_c = {{2{bus.b[WIDTH-1]}}, bus.b};
    end
  end

  // Partial-product selection, add, and arithmetic shift of the acc/Q pair.
  always_comb begin
    m_ext_c   = {{2{m[XW-1]}}, m};
    addend_c  = '0;
    add_inc_c = 1'b0;
    sub_inc_c = 1'b0;
    unique case (op_c)
      PM:      begin addend_c = m_ext_c;                   add_inc_c = 1'b1; end
      P2M:     begin addend_c = {m_ext_c[AW-2:0], 1'b0};   add_inc_c = 1'b1; end
      MM:      begin addend_c = -m_ext_c;                  sub_inc_c = 1'b1; end
      M2M:     begin addend_c = -{m_ext_c[AW-2:0], 1'b0};  sub_inc_c = 1'b1; end
      default: addend_c = '0;
    endcase
    sum_c    = acc + addend_c;
    acc_nx_c = {{2{sum_c[AW-1]}}, sum_c[AW-1:2]};
    q_nx_c   = {sum_c[1:0], q[XW-1:2]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= '0;
      q             <= '0;
      q_m1          <= 1'b0;
      m             <= '0;
      iter          <= '0;
      add_cnt       <= '0;
      sub_cnt       <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.product   <= '0;
      bus.add_count <= '0;
      bus.sub_count <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            state    <= RUN;
            bus.busy <= 1'b1;
            m        <= a_ext_c;
            q        <= b_ext_c;
            q_m1     <= 1'b0;
            acc      <= '0;
            iter     <= '0;
            add_cnt  <= '0;
            sub_cnt  <= '0;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        RUN: begin
          acc     <= acc_nx_c;
          q       <= q_nx_c;
          q_m1    <= q[1];
          iter    <= iter + CNT_W'(1);
          add_cnt <= add_cnt + CNT_W'(add_inc_c);
          sub_cnt <= sub_cnt + CNT_W'(sub_inc_c);
          // Last step: publish the shifted result, including this step's count.
          if (iter == CNT_W'(N_ITER - 1)) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.product   <= {acc_nx_c[WIDTH-3:0], q_nx_c};
            bus.add_count <= add_cnt + CNT_W'(add_inc_c);
            bus.sub_count <= sub_cnt + CNT_W'(sub_inc_c);
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix4_mul.sv
// Self-checking bench for booth_radix4_mul (WIDTH=32): directed plan cases
// plus random operands against an arithmetic reference model.
module tb_booth_radix4_mul;
  localparam int unsigned WIDTH  = 32;
  localparam int          N_ITER = 17;
  localparam int          LAT    = 18;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  booth_radix4_mul_if #(.WIDTH(WIDTH)) bus ();

  booth_radix4_mul #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact product of the extended operands and Booth digit tallies.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input bit ms,
                       output logic [63:0] p, output int ac, output int sc);
    logic [34:0] bx;
    logic [2:0]  t;
    longint      sa, sb;
    logic [63:0] ua, ub;
    bx = {(ms ? {2{mb[31]}} : 2'b00), mb, 1'b0};
    ac = 0;
    sc = 0;
    for (int i = 0; i < N_ITER; i++) begin
      t = bx[2*i +: 3];
      if (t == 3'd1 || t == 3'd2 || t == 3'd3) ac++;
      if (t == 3'd4 || t == 3'd5 || t == 3'd6) sc++;
    end
    if (ms) begin
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      p  = 64'(sa * sb);
    end else begin
      ua = {32'd0, ma};
      ub = {32'd0, mb};
      p  = ua * ub;
    end
  endtask

  // Called #1 after an edge with the DUT in IDLE or DONE; returns #1 after accept.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input bit is);
    bus.start     = 1'b1;
    bus.a         = ia;
    bus.b         = ib;
    bus.is_signed = is;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] ia,
                              input logic [31:0] ib, input bit is);
    logic [63:0] p;
    int ac, sc;
    model(ia, ib, is, p, ac, sc);
    chk({tag, "_product"}, bus.product, p);
    chk({tag, "_add"}, 64'(bus.add_count), 64'(ac));
    chk({tag, "_sub"}, 64'(bus.sub_count), 64'(sc));
  endtask

  task automatic run_op(input string tag, input logic [31:0] ia,
                        input logic [31:0] ib, input bit is);
    int cyc;
    issue(ia, ib, is);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    wait_done(cyc);
    chk({tag, "_latency"}, 64'(cyc + 1), 64'(LAT));
    check_result(tag, ia, ib, is);
  endtask

  initial begin
    int          cyc;
    int          seen_done;
    logic [31:0] ra, rb;
    bit          rs;
    logic [63:0] prev;

    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_product", bus.product, 64'd0);
    chk("rst_add", 64'(bus.add_count), 64'd0);
    chk("rst_sub", 64'(bus.sub_count), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed plan cases
    run_op("p1x6", 32'd1, 32'd6, 1'b1);
    chk("p1x6_add_exact", 64'(bus.add_count), 64'd1);
    chk("p1x6_sub_exact", 64'(bus.sub_count), 64'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(bus.done), 64'd0);
    chk("hold_product", bus.product, 64'd6);
    run_op("neg", 32'(-454), 32'(-2), 1'b1);
    chk("neg_exact", bus.product, 64'd908);
    run_op("ones_u", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("ones_u_exact", bus.product, 64'hFFFF_FFFE_0000_0001);
    run_op("ones_s", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk("ones_s_exact", bus.product, 64'd1);

    // Most-negative square, then back-to-back with start held during DONE
    run_op("minsq", 32'h8000_0000, 32'h8000_0000, 1'b1);
    chk("minsq_exact", bus.product, 64'h4000_0000_0000_0000);
    issue(32'd158, 32'd23, 1'b1);
    chk("b2b_busy_no_idle", 64'(bus.busy), 64'd1);
    chk("b2b_keep_prev", bus.product, 64'h4000_0000_0000_0000);
    wait_done(cyc);
    chk("b2b_latency", 64'(cyc + 1), 64'(LAT));
    chk("b2b_exact", bus.product, 64'd3634);
    check_result("b2b", 32'd158, 32'd23, 1'b1);

    // start during RUN is ignored
    @(posedge clk); #1;
    issue(32'd991, 32'(-88), 1'b1);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 32'd12345;
    bus.b     = 32'd777;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(cyc);
    chk("ign_latency", 64'(cyc + 6), 64'(LAT));
    chk("ign_exact", bus.product, 64'(-64'sd87208));
    check_result("ign", 32'd991, 32'(-88), 1'b1);
    @(posedge clk); #1;
    chk("ign_back_idle", 64'(bus.busy), 64'd0);

    // Asynchronous reset mid-operation
    issue(32'd5000, 32'd3000, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_product", bus.product, 64'd0);
    chk("arst_add", 64'(bus.add_count), 64'd0);
    chk("arst_sub", 64'(bus.sub_count), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
    end
    chk("arst_no_done", 64'(seen_done), 64'd0);
    run_op("post_rst", 32'd5000, 32'd3000, 1'b0);
    chk("post_rst_exact", bus.product, 64'd15000000);

    // Zero operand still takes full latency
    run_op("zero", 32'd0, 32'hDEAD_BEEF, 1'b1);
    chk("zero_exact", bus.product, 64'd0);

    // Random operands, both modes
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i % 8 == 3) rb = 32'h8000_0000;
      prev = bus.product;
      issue(ra, rb, rs);
      chk("rnd_keep_prev", bus.product, prev);
      wait_done(cyc);
      chk("rnd_latency", 64'(cyc + 1), 64'(LAT));
      check_result("rnd", ra, rb, rs);
      if (i % 3 == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
